// File: rtl/cpu_pkg.sv
// Shared CPU constants used by the fetch stage and its buffer.
package cpu_pkg;

    localparam int PC_W_DEFAULT     = 5;
    localparam int INSTR_W          = 32;
    localparam int RESET_PC_DEFAULT = 0;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry valid/ready FIFO holding {pc, instr} fetch results, with synchronous flush.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = PC_W_DEFAULT + INSTR_W,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push_valid,
    input  logic [DATA_W-1:0] push_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              pop;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    // Empty FIFO presents zeros so stale storage never leaks onto the outputs.
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    // The producer only pushes when it holds a credit, so a push never meets a full FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_valid) wr_ptr <= bump(wr_ptr);
            if (pop)        rd_ptr <= bump(rd_ptr);
            count <= count + CNT_W'(push_valid) - CNT_W'(pop);
        end
    end

    // NOTE: storage has no reset; validity lives entirely in count, which is reset.
    always_ff @(posedge clk) begin
        if (push_valid && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, synchronous-ROM fetch issue and a credit-checked fetch buffer.
// Define IF_PERF_CNT_EN to add the saturating redirect_count output.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int PC_W      = PC_W_DEFAULT,
    parameter int RESET_PC  = RESET_PC_DEFAULT,
    parameter int BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               should_jump,
    input  logic [PC_W-1:0]    jump_target,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [PC_W-1:0]    if_pc,
    output logic [INSTR_W-1:0] if_instr
`ifdef IF_PERF_CNT_EN
    ,
    output logic [15:0]        redirect_count
`endif
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    logic [PC_W-1:0]         pc;
    logic                    inflight;
    logic [PC_W-1:0]         inflight_pc;
    logic [CNT_W-1:0]        fifo_count;
    logic [CNT_W:0]          occupancy;
    logic                    issue;
    logic                    pop;
    logic [PC_W+INSTR_W-1:0] head;

    assign imem_addr = pc;
    assign pop       = if_valid && if_ready;
    assign if_pc     = head[PC_W+INSTR_W-1:INSTR_W];
    assign if_instr  = head[INSTR_W-1:0];

    // Issue only if the buffer can still absorb this fetch after the in-flight one lands.
    always_comb begin
        occupancy = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
        issue     = occupancy < (CNT_W+1)'(BUF_DEPTH);
    end

    // A redirect also kills any fetch issued in the same cycle, hence inflight <= 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= PC_W'(RESET_PC);
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (should_jump) begin
            pc       <= jump_target;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc          <= pc + 1'b1;
                inflight_pc <= pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH  (BUF_DEPTH),
        .DATA_W (PC_W + INSTR_W)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .flush      (should_jump),
        .push_valid (inflight),
        .push_data  ({inflight_pc, imem_rdata}),
        .out_valid  (if_valid),
        .out_ready  (if_ready),
        .out_data   (head),
        .count      (fifo_count)
    );

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_count <= '0;
        end else if (should_jump && redirect_count != 16'hFFFF) begin
            redirect_count <= redirect_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: ROM[i] = 0x1000_0000 + i, outputs sampled on the falling edge.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        should_jump;
    logic [4:0]  jump_target;
    logic [4:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [4:0]  if_pc;
    logic [31:0] if_instr;
`ifdef IF_PERF_CNT_EN
    logic [15:0] redirect_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    instr_fetch #(
        .PC_W      (5),
        .RESET_PC  (0),
        .BUF_DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .should_jump (should_jump),
        .jump_target (jump_target),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_pc       (if_pc),
        .if_instr    (if_instr)
`ifdef IF_PERF_CNT_EN
        ,
        .redirect_count (redirect_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read instruction ROM
    always @(posedge clk) imem_rdata <= 32'h1000_0000 + 32'(imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic expect_head(input int pc);
        check("head_valid", 32'(if_valid), 32'd1);
        check("head_pc", 32'(if_pc), 32'(pc));
        check("head_instr", if_instr, 32'h1000_0000 + 32'(pc));
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wrap_seq [4];
        wrap_seq = '{30, 31, 0, 1};

        rst         = 1'b1;
        should_jump = 1'b0;
        jump_target = '0;
        if_ready    = 1'b1;
        repeat (2) step();

        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_pc", 32'(if_pc), 32'd0);
        check("rst_instr", if_instr, 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        rst = 1'b0;

        // First edge issues pc 0; valid rises on the second edge.
        step();
        check("rel_valid_n1", 32'(if_valid), 32'd0);
        check("rel_addr_n1", 32'(imem_addr), 32'd1);
        step();
        expect_head(0);
        for (int i = 1; i <= 3; i++) begin
            step();
            expect_head(i);
        end

        // Decode stall while pc 3 is presented
        check("stall_addr_start", 32'(imem_addr), 32'd5);
        if_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            expect_head(3);
            check("stall_addr", 32'(imem_addr), 32'd5);
        end
        if_ready = 1'b1;
        for (int i = 4; i <= 7; i++) begin
            step();
            expect_head(i);
        end

        // One-cycle redirect to 20 while pc 7 is presented (pop discarded)
        should_jump = 1'b1;
        jump_target = 5'd20;
        step();
        should_jump = 1'b0;
        check("jmp_valid_n1", 32'(if_valid), 32'd0);
        check("jmp_addr_n1", 32'(imem_addr), 32'd20);
        step();
        check("jmp_valid_n2", 32'(if_valid), 32'd0);
        step();
        expect_head(20);
        step();
        expect_head(21);

        // PC wrap: redirect to 30 -> 30, 31, 0, 1
        should_jump = 1'b1;
        jump_target = 5'd30;
        step();
        should_jump = 1'b0;
        check("wrap_valid_n1", 32'(if_valid), 32'd0);
        step();
        check("wrap_valid_n2", 32'(if_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            expect_head(wrap_seq[i]);
        end

        // should_jump held three cycles; only the last target survives
        should_jump = 1'b1;
        jump_target = 5'd10;
        step();
        check("multi_valid_1", 32'(if_valid), 32'd0);
        jump_target = 5'd12;
        step();
        check("multi_valid_2", 32'(if_valid), 32'd0);
        jump_target = 5'd14;
        step();
        should_jump = 1'b0;
        check("multi_valid_3", 32'(if_valid), 32'd0);
        check("multi_addr", 32'(imem_addr), 32'd14);
        step();
        check("multi_valid_4", 32'(if_valid), 32'd0);
        step();
        expect_head(14);
        step();
        expect_head(15);

        // Redirect with a full buffer
        if_ready = 1'b0;
        step();
        expect_head(15);
        check("full_addr_hold", 32'(imem_addr), 32'd17);
        should_jump = 1'b1;
        jump_target = 5'd3;
        step();
        should_jump = 1'b0;
        if_ready    = 1'b1;
        check("full_flush_valid", 32'(if_valid), 32'd0);
        check("full_resume_addr", 32'(imem_addr), 32'd3);
        step();
        check("full_valid_n2", 32'(if_valid), 32'd0);
        step();
        expect_head(3);
        step();
        expect_head(4);

        // rst and should_jump together: reset wins, asynchronously
        rst         = 1'b1;
        should_jump = 1'b1;
        jump_target = 5'd25;
        #1;
        check("async_rst_valid", 32'(if_valid), 32'd0);
        check("async_rst_addr", 32'(imem_addr), 32'd0);
        step();
        check("rst_jmp_valid", 32'(if_valid), 32'd0);
        check("rst_jmp_pc", 32'(if_pc), 32'd0);
        check("rst_jmp_instr", if_instr, 32'd0);
        check("rst_jmp_addr", 32'(imem_addr), 32'd0);
        rst         = 1'b0;
        should_jump = 1'b0;
        step();
        check("rst_jmp_valid_n1", 32'(if_valid), 32'd0);
        step();
        expect_head(0);
        step();
        expect_head(1);

`ifdef IF_PERF_CNT_EN
        check("perf_after_rst", 32'(redirect_count), 32'd0);
        for (int r = 0; r < 3; r++) begin
            should_jump = 1'b1;
            jump_target = 5'd8;
            step();
            should_jump = 1'b0;
            step();
        end
        check("perf_three", 32'(redirect_count), 32'd3);
        should_jump = 1'b1;
        for (int r = 0; r < 32'h10002; r++) step();
        should_jump = 1'b0;
        step();
        check("perf_saturate", 32'(redirect_count), 32'h0000_FFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter PC_W, default 5: PC / instruction-index width.
REQ-002 SHALL have parameter RESET_PC, default 0: first instruction index fetched after reset.
REQ-003 SHALL have parameter BUF_DEPTH, default 2: fetch-buffer entries.
REQ-004 SHALL have port clk  in  1: single clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1: reset, asynchronous, active-high.
REQ-006 SHALL have port should_jump  in  1: redirect request from the mem/writeback stage.
REQ-007 SHALL have port jump_target  in  PC_W: redirect instruction index.
REQ-008 SHALL have port imem_addr  out  PC_W: instruction ROM address.
REQ-009 SHALL have port imem_rdata  in  32: ROM data, synchronous read, valid one cycle after the address.
REQ-010 SHALL have port if_valid  out  1: fetched instruction available to decode.
REQ-011 SHALL have port if_ready  in  1: decode accepts (pop when if_valid && if_ready).
REQ-012 SHALL have port if_pc  out  PC_W: index of the presented instruction.
REQ-013 SHALL have port if_instr  out  32: presented instruction word.

Function
REQ-014 SHALL hold a fetch PC; each issued fetch drives imem_addr = PC, then PC increments by 1 modulo 2^PC_W (2^PC_W-1 wraps to 0).
REQ-015 SHALL issue a fetch in a cycle only when (buffer count + in-flight fetch - pop this cycle) < BUF_DEPTH; otherwise PC and imem_addr hold.
REQ-016 SHALL push {addr, imem_rdata} into the buffer one cycle after issue, unless that fetch was killed.
REQ-017 SHALL present the buffer head on if_pc/if_instr; if_valid = buffer not empty; outputs SHALL be stable while if_valid && !if_ready.
REQ-018 SHALL, on a should_jump-sampled edge: load PC with jump_target, flush the buffer, kill the in-flight fetch; if_valid SHALL be 0 in the following cycle.
REQ-019 SHALL drive imem_addr = jump_target in the cycle after the redirect edge; the target's instruction SHALL reach if_valid two cycles after the redirect edge.
REQ-020 SHALL give redirect priority over a simultaneous pop; the popped entry is discarded, not counted as delivered.
REQ-021 SHALL, with should_jump held high N cycles, re-redirect every cycle; only the last target survives.
REQ-022 SHALL, when a redirect occurs with a full buffer, flush it and resume issue in the next cycle.
REQ-023 SHALL sustain one instruction per cycle into decode when if_ready stays high.

Reset
REQ-024 SHALL, while rst is high, force: PC = RESET_PC, imem_addr = RESET_PC, buffer empty, in-flight cleared, if_valid = 0, if_pc = 0, if_instr = 0.
REQ-025 SHALL give rst priority over should_jump; rst asserted mid-operation SHALL discard all buffered and in-flight fetches.
REQ-026 SHALL issue RESET_PC in the first cycle after rst deasserts; if_valid SHALL rise two cycles after deassertion.

Configuration
REQ-027 SHALL, with IF_PERF_CNT_EN defined, add port redirect_count  out  16: count of redirect edges, reset to 0, saturating at 0xFFFF.
REQ-028 SHALL, without IF_PERF_CNT_EN, omit the port and counter; all other behaviour identical.

Structure
REQ-029 SHALL take PC_W default, INSTR_W = 32 and RESET_PC default from shared package cpu_pkg.
REQ-030 SHALL implement the buffer as sub-module fetch_fifo: BUF_DEPTH-entry valid/ready FIFO with synchronous flush input.

Verification
REQ-031 SHALL test reset release, ROM[i] = 0x1000_0000+i, if_ready = 1 -> if_valid rises 2 cycles later; if_pc = 0,1,2,... one per cycle with matching words.
REQ-032 SHALL test if_ready = 0 for 5 cycles after pc 3 is presented -> if_pc/if_instr held at 3; imem_addr stalls at 5; resume delivers 4,5,6 with no gap or duplicate.
REQ-033 SHALL test one-cycle should_jump, jump_target = 20, while pc 7 is presented -> if_valid 0 next cycle; imem_addr = 20; next delivered pc = 20; pcs 8/9 never delivered.
REQ-034 SHALL test PC at 31 with PC_W = 5 -> delivered sequence 30, 31, 0, 1.
REQ-035 SHALL test should_jump and rst asserted together -> reset wins; first delivered pc = RESET_PC.
REQ-036 SHALL test IF_PERF_CNT_EN with 3 redirects -> redirect_count = 3; after forcing 0x10005 redirects -> 0xFFFF.
